uart_rx_os: RTL
===============

# uart_rx_os

Parametrised, oversampling UART receiver for the APB UART IP, the next generation of the single-rate receiver. It synchronises the asynchronous `rx` line, detects the start bit on an oversample tick, and samples each bit at its centre. Data width, parity and stop-bit count are configurable, with parity and framing errors reported. Received words go to the RX FIFO / APB register layer as a one-cycle valid pulse plus held data and status.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal 5..9, LSB first.
- `OVERSAMPLE`, default 16: `sample_tick` periods per bit; even, 8..32.
- `PARITY_EN`, default 0: 1 means one parity bit follows the data.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored if `PARITY_EN`=0.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk` in, 1: clock.
- `rst` in, 1: reset; synchronous, active-high.
- `sample_tick` in, 1: one-clk pulse at baud×`OVERSAMPLE` from the baud generator.
- `rx_en` in, 1: permits detection of a new start bit.
- `rx` in, 1: asynchronous serial input; idles high.
- `data_out` out, `DATA_BITS`: last received word; held until the next `data_valid`.
- `data_valid` out, 1: one-clk pulse when a frame completes.
- `parity_err` out, 1: parity mismatch for the word in `data_out`.
- `frame_err` out, 1: a stop bit was sampled low for the word in `data_out`.
- `busy` out, 1: high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1. All decisions use the synchronised value `rx_s`.
- Counters:
  - `tick_cnt`: width clog2(`OVERSAMPLE`); advances only on `sample_tick`.
  - `bit_cnt`: width clog2(`DATA_BITS`+1).
- States are IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On `sample_tick` with `rx_en`=1 and `rx_s`=0: go to START, `tick_cnt`=0.
  - A start condition without `sample_tick` waits for the next tick.
- START:
  - On the tick where `tick_cnt`=`OVERSAMPLE`/2-1: if `rx_s`=0, go to DATA with `tick_cnt`=0 and `bit_cnt`=0.
  - If `rx_s`=1 at that tick, it is a false start (glitch): return to IDLE with no output change.
- DATA:
  - On the tick where `tick_cnt`=`OVERSAMPLE`-1 (the bit centre): shift `rx_s` into the MSB of the shift register (LSB-first), increment `bit_cnt`, set `tick_cnt`=0.
  - After `DATA_BITS` samples: go to PARITY if `PARITY_EN`, otherwise STOP.
- PARITY: sample at the centre. Error when the XOR of the data bits and the parity bit is not 0 (even) or not 1 (odd).
- STOP:
  - Sample each of the `STOP_BITS` stop bits at its centre. Any low sample sets the frame error.
  - After the last stop sample, in the same clk: load `data_out`, `parity_err`, `frame_err`; pulse `data_valid`; go to IDLE.
- A frame with errors is still delivered (`data_valid`=1 with the flag set). A break (all zero) gives `frame_err`=1 and `data_out`=0.
- `rx_en` only gates new start detection. Dropping it mid-frame does not abort the frame.
- `parity_err` is always 0 when `PARITY_EN`=0.
- Arithmetic: counters wrap only by explicit clear. `tick_cnt` never exceeds `OVERSAMPLE`-1.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, state IDLE, shift register 0. Synchroniser flops reset to 1.
- `rst` mid-frame returns to IDLE on the next edge. The partial frame is discarded with no `data_valid`.
- Latency from `rx` to `rx_s` is 2 clk.
- `data_valid` is registered: it asserts in the clk after the edge that consumes the final stop-bit centre tick, and lasts exactly 1 clk.
- The flags change only together with `data_valid`.
- The receiver re-enters IDLE at the last stop-bit centre. A start edge arriving half a bit later (back-to-back frames) is detected without loss.
- `busy` rises in the clk after the start is detected. It falls in the same clk that `data_valid` rises.
- The block tolerates ±3% baud mismatch at `OVERSAMPLE`=16.

## Test plan
- Reset behaviour: defaults, `sample_tick` every 4 clk. Send 0xA5 with 1 stop bit → one `data_valid` pulse, `data_out`=0xA5, both error flags 0. Then assert `rst` mid-frame while sending 0x3C → no `data_valid`, outputs return to reset values, and the next frame 0x3C is received cleanly.
- False start: drive a low glitch lasting 3 sample ticks → return to IDLE, no `data_valid`, `busy` deasserts.
- Parity check: `PARITY_EN`=1, `PARITY_ODD`=0. Send 0x07 with parity bit 1 → `parity_err`=0. Send 0x07 with parity bit 0 → `parity_err`=1 and `data_out`=0x07.
- Framing error: `STOP_BITS`=2, send 0x81 with the second stop bit low → `frame_err`=1. Send a break → `data_out`=0x00, `frame_err`=1.
- Back-to-back and width: send 0x55, 0xAA, 0xFF back-to-back with no idle gap → three pulses in order, all correct. Then `DATA_BITS`=5, send 0x1B → `data_out`=0x1B.
- Enable gating and baud skew: deassert `rx_en` mid-frame → the frame completes. Keep `rx_en`=0 and send 0x12 → not received. Send 0x5A at baud +3% and −3% → received correctly.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronises rx, qualifies the start bit at its
// centre, samples data/parity/stop bits at their centres and reports errors.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD_SEL   = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_acc_q, perr_acc_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0]   data_out_q, data_out_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   ferr_now;

    // NOTE: every registered signal uses <= so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            // NOTE: the shift register is ordinary flops, not a RAM, so resetting it is cheap and keeps data_out deterministic.
            shift_q    <= '0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign ferr_now = ferr_acc_q | ~rx_s_q;

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        data_out_d = data_out_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        valid_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sample_tick && rx_en && !rx_s_q) begin
                    state_d = S_START;
                    tick_d  = '0;
                end
            end
            S_START: begin
                // Half a bit after the falling edge: still low means a real start.
                if (sample_tick) begin
                    if (tick_q == TICK_HALF) begin
                        if (!rx_s_q) begin
                            state_d    = S_DATA;
                            tick_d     = '0;
                            bit_d      = '0;
                            perr_acc_d = 1'b0;
                            ferr_acc_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (sample_tick) begin
                    if (tick_q == TICK_LAST) begin
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (sample_tick) begin
                    if (tick_q == TICK_LAST) begin
                        perr_acc_d = (^shift_q) ^ rx_s_q ^ ODD_SEL;
                        tick_d     = '0;
                        state_d    = S_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                // bit_q is reused here to count stop bits.
                if (sample_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d     = '0;
                        ferr_acc_d = ferr_now;
                        if (bit_q == STOP_LAST) begin
                            data_out_d = shift_q;
                            perr_d     = (PARITY_EN != 0) && perr_acc_q;
                            ferr_d     = ferr_now;
                            valid_d    = 1'b1;
                            bit_d      = '0;
                            state_d    = S_IDLE;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != S_IDLE);

endmodule
